// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: ALU/load write ports, read ports and buffer status of the writeback register file
interface writeback_regfile_if;
  logic        alu_write_req;
  logic [4:0]  alu_write_addr;
  logic [31:0] alu_write_data;
  logic        write_req;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  src1_addr;
  logic [4:0]  src2_addr;
  logic [31:0] src1_value;
  logic [31:0] src2_value;
  logic        stall_req;
  logic [1:0]  pending_count;
  logic        overflow_err;
  modport master (
    output alu_write_req, alu_write_addr, alu_write_data, write_req, write_addr, write_data, src1_addr, src2_addr,
    input  src1_value, src2_value, stall_req, pending_count, overflow_err
  );
  modport slave (
    input  alu_write_req, alu_write_addr, alu_write_data, write_req, write_addr, write_data, src1_addr, src2_addr,
    output src1_value, src2_value, stall_req, pending_count, overflow_err
  );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile: 32x32 register file; ALU writes win the single write port, loads wait in a 2-entry FIFO
module writeback_regfile (
  input logic clk,
  input logic reset,
  writeback_regfile_if.slave bus
);
  logic [31:0] regs [32];
  logic [1:0]  buf_v;
  logic [4:0]  buf_a [2];
  logic [31:0] buf_d [2];
  logic [1:0]  count;
  logic        ovf;
  logic        alu_we, ld_we, pop, bypass, squash, enq, drop;
  logic [1:0]  cnt_p, kept_v, nv;
  logic [4:0]  na [2];
  logic [31:0] nd [2];
  logic        c_we;
  logic [4:0]  c_a;
  logic [31:0] c_d;
  logic [4:0]  ra [2];
  logic [31:0] rv [2];
  assign alu_we = bus.alu_write_req && bus.alu_write_addr != 5'd0;
  assign ld_we  = bus.write_req && bus.write_addr != 5'd0;
  assign pop    = !alu_we && count != 2'd0;
  assign bypass = !alu_we && count == 2'd0 && ld_we;
  assign squash = alu_we && ld_we && bus.write_addr == bus.alu_write_addr;
  assign enq    = ld_we && !bypass && !squash && (count != 2'd2 || pop);
  assign drop   = ld_we && !bypass && !squash && !(count != 2'd2 || pop);
  assign cnt_p  = count - 2'(pop);
  // an ALU commit makes any older buffered load to the same register stale
  assign kept_v[0] = buf_v[0] && !(alu_we && buf_a[0] == bus.alu_write_addr);
  assign kept_v[1] = buf_v[1] && !(alu_we && buf_a[1] == bus.alu_write_addr);
  always_comb begin
    nv[0] = enq && cnt_p == 2'd0 ? 1'b1 : pop ? kept_v[1] : kept_v[0];
    na[0] = enq && cnt_p == 2'd0 ? bus.write_addr : pop ? buf_a[1] : buf_a[0];
    nd[0] = enq && cnt_p == 2'd0 ? bus.write_data : pop ? buf_d[1] : buf_d[0];
    nv[1] = enq && cnt_p == 2'd1 ? 1'b1 : pop ? 1'b0 : kept_v[1];
    na[1] = enq && cnt_p == 2'd1 ? bus.write_addr : buf_a[1];
    nd[1] = enq && cnt_p == 2'd1 ? bus.write_data : buf_d[1];
    c_we  = alu_we || (pop && buf_v[0]) || bypass;
    c_a   = alu_we ? bus.alu_write_addr : pop ? buf_a[0] : bus.write_addr;
    c_d   = alu_we ? bus.alu_write_data : pop ? buf_d[0] : bus.write_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      buf_v <= '0;
      buf_a <= '{default: '0};
      buf_d <= '{default: '0};
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (c_we) regs[c_a] <= c_d;
      buf_v <= nv;
      buf_a <= na;
      buf_d <= nd;
      count <= cnt_p + 2'(enq);
      if (drop) ovf <= 1'b1;
    end
  end
  assign ra[0] = bus.src1_addr;
  assign ra[1] = bus.src2_addr;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rv[p] = ra[p] == 5'd0 ? 32'd0 :
                   alu_we && bus.alu_write_addr == ra[p] ? bus.alu_write_data :
                   ld_we && bus.write_addr == ra[p] ? bus.write_data :
                   buf_v[1] && buf_a[1] == ra[p] ? buf_d[1] :
                   buf_v[0] && buf_a[0] == ra[p] ? buf_d[0] : regs[ra[p]];
  end
  assign bus.src1_value    = rv[0];
  assign bus.src2_value    = rv[1];
  assign bus.pending_count = count;
  assign bus.stall_req     = count == 2'd2;
  assign bus.overflow_err  = ovf;
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset (name the clock and reset ports as the codebase does; polarity and synchronicity fixed).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alu_write_req  in  1  ALU-result write valid.
REQ-005 alu_write_addr  in  5  ALU destination register.
REQ-006 alu_write_data  in  32  ALU result.
REQ-007 write_req  in  1  load-result write valid, from the data-memory stage.
REQ-008 write_addr  in  5  load destination register.
REQ-009 write_data  in  32  load data.
REQ-010 src1_addr, src2_addr  in  5 each  read-port register indices.
REQ-011 src1_value, src2_value  out  32 each  combinational read data.
REQ-012 stall_req  out  1  load buffer full; upstream holds the load stage.
REQ-013 pending_count  out  2  occupied load-buffer slots (0..2).
REQ-014 overflow_err  out  1  sticky: a load write was dropped.

Function
REQ-015 SHALL hold 32x32 registers; x0 SHALL always read 0, and writes with addr 0 on either port SHALL be ignored and never enqueued.
REQ-016 SHALL commit at most one array write per rising edge.
REQ-017 Commit priority: valid ALU write (addr!=0) first; else buffer head; else the incoming load directly.
REQ-018 Load buffer: 2-entry in-order FIFO of {valid, addr, data}.
REQ-019 The incoming load SHALL bypass the buffer only when no ALU write occurs and the buffer is empty.
REQ-020 Otherwise the incoming load SHALL be enqueued if count<2, or if count==2 and the head pops that same cycle.
REQ-021 If the load cannot be enqueued, it SHALL be dropped and overflow_err SHALL set and remain 1 until reset.
REQ-022 A head pop SHALL occur on any cycle without an ALU commit; an invalid head SHALL pop without writing the array.
REQ-023 Age rule: a simultaneous load write is older than the ALU write.
REQ-024 On an ALU commit to addr A, all buffer entries with addr A SHALL be cleared to invalid; they still occupy their slots.
REQ-025 On an ALU commit to addr A, a simultaneous incoming load to A SHALL be discarded (not enqueued, no overflow_err).
REQ-026 Read priority per port: addr 0 gives 0; else ALU write this cycle; else incoming load this cycle; else newest valid buffer entry; else older valid entry; else array.
REQ-027 stall_req SHALL equal (pending_count==2), combinational from registered count.
REQ-028 pending_count SHALL count valid and invalid occupied slots.
REQ-029 Latency: a write presented in cycle N SHALL be visible through bypass in cycle N, and in the array or buffer from cycle N+1.

Reset
REQ-030 On reset: all 32 registers, buffer entries, pending_count, and overflow_err SHALL clear to 0.
REQ-031 On reset, stall_req SHALL be 0.
REQ-032 Reset SHALL override any simultaneous write; in-flight buffered loads are discarded.

Verification
REQ-033 Load only: write_req=1, addr 5, data 0xDEADBEEF -> same-cycle src1_addr=5 reads 0xDEADBEEF; next cycle array x5=0xDEADBEEF; pending_count=0.
REQ-034 Conflict: same cycle ALU x3=0x11 and load x4=0x22 -> x3 committed, pending_count=1; next idle cycle x4=0x22 committed, pending_count=0.
REQ-035 Squash: load x7=0xAA buffered, then ALU x7=0xBB -> entry invalidated; after drain x7=0xBB, never 0xAA.
REQ-036 Overflow: ALU writes every cycle with loads on 3 consecutive cycles -> pending_count=2, stall_req=1, third load dropped, overflow_err=1 until reset.
REQ-037 x0: ALU and load both write x0=0xFFFFFFFF -> src1 of x0 reads 0, nothing enqueued.
REQ-038 Reset mid-operation: pending_count=2, assert reset one cycle -> all outputs 0, registers read 0, buffered data never committed.
